// File: rtl/reg_wb_queue.sv
// reg_wb_queue: register write-back queue feeding a single rf write port.
// Ports: clk, rst_n (async low); in_valid/in_ready/in_addr/in_data push;
//   flush; wb_we/wb_addr/wb_data rf write; rd1/rd2_addr lookups;
//   fwd1/fwd2_hit, fwd1/fwd2_data forwarding (macro WBQ_FWD_EN); count.
module reg_wb_queue #(
    parameter int DEPTH = 4,
    parameter int DW    = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [4:0]               in_addr,
    input  logic [DW-1:0]            in_data,
    input  logic                     flush,
    output logic                     wb_we,
    output logic [4:0]               wb_addr,
    output logic [DW-1:0]            wb_data,
    input  logic [4:0]               rd1_addr,
    input  logic [4:0]               rd2_addr,
    output logic                     fwd1_hit,
    output logic                     fwd2_hit,
    output logic [DW-1:0]            fwd1_data,
    output logic [DW-1:0]            fwd2_data,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [4:0]    mem_addr [DEPTH];
    logic [DW-1:0] mem_data [DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [CW-1:0] cnt;

    logic push;
    logic store;
    logic pop;

    assign in_ready = (cnt != CW'(DEPTH));
    assign push     = in_valid && in_ready && !flush;
    // x0 writes complete the handshake but are never stored
    assign store    = push && (in_addr != 5'd0);
    assign pop      = (cnt != '0) && !flush;

    assign wb_we   = (cnt != '0);
    assign wb_addr = mem_addr[head];
    assign wb_data = mem_data[head];
    assign count   = cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head <= '0;
            tail <= '0;
            cnt  <= '0;
        end else if (flush) begin
            head <= tail;
            cnt  <= '0;
        end else begin
            if (store)
                tail <= tail + 1'b1;
            if (pop)
                head <= head + 1'b1;
            if (store && !pop)
                cnt <= cnt + 1'b1;
            else if (pop && !store)
                cnt <= cnt - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (store) begin
            mem_addr[tail] <= in_addr;
            mem_data[tail] <= in_data;
        end
    end

`ifdef WBQ_FWD_EN
    // Walk oldest to youngest so the youngest match wins.
    always_comb begin
        logic [PW-1:0] idx;
        fwd1_hit  = 1'b0;
        fwd2_hit  = 1'b0;
        fwd1_data = '0;
        fwd2_data = '0;
        idx       = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = head + PW'(k);
            if (CW'(k) < cnt) begin
                if (rd1_addr != 5'd0 && mem_addr[idx] == rd1_addr) begin
                    fwd1_hit  = 1'b1;
                    fwd1_data = mem_data[idx];
                end
                if (rd2_addr != 5'd0 && mem_addr[idx] == rd2_addr) begin
                    fwd2_hit  = 1'b1;
                    fwd2_data = mem_data[idx];
                end
            end
        end
    end
`else
    logic unused_rd;
    assign unused_rd = ^{rd1_addr, rd2_addr};
    assign fwd1_hit  = 1'b0;
    assign fwd2_hit  = 1'b0;
    assign fwd1_data = '0;
    assign fwd2_data = '0;
`endif

endmodule
